wb_master_skid_bridge: RTL and testbench

- Registered bridge between a pipelined Wishbone master on a `wishbone` interface port and a flat-signal Wishbone slave.
- Adds a 2-entry request skid buffer, a bounded outstanding-transaction counter and a response watchdog.
- Sits between CPU or ihex-loader masters and flat peripheral or memory buses. Cuts the combinational stall and ack paths and bounds hangs from dead slaves.

---
 rtl/wb_master_skid_bridge.sv | 125 ++++++++++++
 tb/tb_wb_master_skid_bridge.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_master_skid_bridge.sv
// wb_master_skid_bridge: pipelined Wishbone master to flat slave bridge with 2-entry skid buffer, outstanding limit and watchdog.
// Define WB_BRIDGE_STATS_EN to add saturating req_count/timeout_count outputs.
module wb_master_skid_bridge #(
    parameter int MAX_OUTSTANDING = 4,
    parameter int TIMEOUT_CYCLES  = 256,
    parameter int CNT_W           = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             wb_cyc,
    input  logic             wb_stb,
    input  logic             wb_we,
    input  logic [3:0]       wb_sel,
    input  logic [29:0]      wb_addr,
    input  logic [31:0]      wb_mosi_data,
    output logic             wb_ack,
    output logic             wb_err,
    output logic             wb_stall,
    output logic [31:0]      wb_miso_data,
    output logic             cyc,
    output logic             stb,
    output logic             we,
    output logic [3:0]       sel,
    output logic [29:0]      addr,
    output logic [31:0]      mosi_data,
    input  logic             ack,
    input  logic             err,
    input  logic             stall,
    input  logic [31:0]      miso_data,
    output logic [CNT_W-1:0] outstanding,
    output logic             timeout
`ifdef WB_BRIDGE_STATS_EN
    ,
    output logic [15:0]      req_count,
    output logic [7:0]       timeout_count
`endif
);
    localparam int WD_W = TIMEOUT_CYCLES > 2 ? $clog2(TIMEOUT_CYCLES) : 1;
    typedef enum logic [1:0] {IDLE, ACTIVE, ABORT} state_t;
    state_t state, state_nx;
    logic or_v, sr_v, sr_v_nx, sr_we;
    logic [3:0] sr_sel;
    logic [29:0] sr_addr;
    logic [31:0] sr_data;
    logic [WD_W-1:0] wd;
    logic busy, acc, issue, resp, run, expire, flush, or_free;
    assign busy    = outstanding != '0;
    assign stb     = or_v & (outstanding < CNT_W'(MAX_OUTSTANDING)) & (state == ACTIVE);
    assign issue   = stb & !stall;
    assign acc     = wb_cyc & wb_stb & !wb_stall;
    // Responses count only while the flat cycle is live and something is actually owed.
    assign resp    = (ack | err) & cyc & wb_cyc & busy;
    assign run     = (state == ACTIVE) & wb_cyc & busy & !(ack | err);
    assign expire  = run & (TIMEOUT_CYCLES != 0) & (wd == WD_W'(TIMEOUT_CYCLES - 1));
    assign flush   = !wb_cyc | expire;
    assign or_free = !or_v | issue;
    assign sr_v_nx = !flush & !or_free & (sr_v | acc);
    always_comb begin
        state_nx = !wb_cyc ? IDLE : state == IDLE ? ACTIVE : expire ? ABORT : state;
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            cyc          <= 1'b0;
            or_v         <= 1'b0;
            sr_v         <= 1'b0;
            we           <= 1'b0;
            sel          <= '0;
            addr         <= '0;
            mosi_data    <= '0;
            sr_we        <= 1'b0;
            sr_sel       <= '0;
            sr_addr      <= '0;
            sr_data      <= '0;
            wb_ack       <= 1'b0;
            wb_err       <= 1'b0;
            wb_stall     <= 1'b0;
            wb_miso_data <= '0;
            outstanding  <= '0;
            timeout      <= 1'b0;
            wd           <= '0;
        end else begin
            state        <= state_nx;
            cyc          <= state_nx == ACTIVE;
            wb_stall     <= sr_v_nx | (state_nx == ABORT);
            wb_ack       <= ack & !err & resp;
            wb_err       <= (err & resp) | expire;
            timeout      <= expire;
            wd           <= run & !expire ? wd + 1'b1 : '0;
            outstanding  <= flush || state != ACTIVE ? '0 :
                            issue & !resp ? outstanding + 1'b1 :
                            resp & !issue ? outstanding - 1'b1 : outstanding;
            sr_v         <= sr_v_nx;
            or_v         <= !flush & (or_free ? sr_v | acc : 1'b1);
            if (ack)
                wb_miso_data <= miso_data;
            // A free output register always takes the oldest pending request: skid first, then the new accept.
            if (or_free) begin
                we        <= sr_v ? sr_we : wb_we;
                sel       <= sr_v ? sr_sel : wb_sel;
                addr      <= sr_v ? sr_addr : wb_addr;
                mosi_data <= sr_v ? sr_data : wb_mosi_data;
            end
            if (!or_free && acc) begin
                sr_we   <= wb_we;
                sr_sel  <= wb_sel;
                sr_addr <= wb_addr;
                sr_data <= wb_mosi_data;
            end
        end
    end
`ifdef WB_BRIDGE_STATS_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            req_count     <= '0;
            timeout_count <= '0;
        end else begin
            if (issue && req_count != '1)
                req_count <= req_count + 1'b1;
            if (expire && timeout_count != '1)
                timeout_count <= timeout_count + 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_wb_master_skid_bridge.sv
// tb_wb_master_skid_bridge: scoreboard bench for wb_master_skid_bridge with MAX_OUTSTANDING=4, TIMEOUT_CYCLES=16.
module tb_wb_master_skid_bridge;
    logic clk = 0, reset_n = 0;
    logic wb_cyc = 0, wb_stb = 0, wb_we = 0;
    logic [3:0] wb_sel = 0;
    logic [29:0] wb_addr = 0;
    logic [31:0] wb_mosi_data = 0;
    logic wb_ack, wb_err, wb_stall;
    logic [31:0] wb_miso_data;
    logic cyc, stb, we;
    logic [3:0] sel;
    logic [29:0] addr;
    logic [31:0] mosi_data;
    logic ack = 0, err = 0, stall = 0;
    logic [31:0] miso_data = 0;
    logic [3:0] outstanding;
    logic timeout;
`ifdef WB_BRIDGE_STATS_EN
    logic [15:0] req_count;
    logic [7:0] timeout_count;
`endif

    wb_master_skid_bridge #(.MAX_OUTSTANDING(4), .TIMEOUT_CYCLES(16), .CNT_W(4)) dut (
        .clk(clk), .reset_n(reset_n),
        .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we), .wb_sel(wb_sel), .wb_addr(wb_addr),
        .wb_mosi_data(wb_mosi_data), .wb_ack(wb_ack), .wb_err(wb_err), .wb_stall(wb_stall),
        .wb_miso_data(wb_miso_data), .cyc(cyc), .stb(stb), .we(we), .sel(sel), .addr(addr),
        .mosi_data(mosi_data), .ack(ack), .err(err), .stall(stall), .miso_data(miso_data),
        .outstanding(outstanding), .timeout(timeout)
`ifdef WB_BRIDGE_STATS_EN
        , .req_count(req_count), .timeout_count(timeout_count)
`endif
    );

    typedef struct { logic we; logic [3:0] sel; logic [29:0] addr; logic [31:0] data; } req_t;
    typedef struct { logic is_err; logic is_rd; logic [31:0] data; } rsp_t;
    typedef struct { int due; logic [29:0] addr; logic we; } pend_t;
    req_t iss_q[$];
    rsp_t rsp_q[$];
    pend_t pend[$];
    int iss_edges[$], ack_edges[$];
    int n_tests = 0, n_fail = 0, ncyc = 0;
    int slv_delay = 1, slv_stall_left = 0, last_rsp_edge = 0, n_rsp = 0, stb_hi = 0, to_hi = 0, max_outs = 0;
    bit slv_mute = 0, force_ack = 0, hold = 0;
    logic [66:0] hold_val = '0;

    always #5 clk = ~clk;
    always @(posedge clk) ncyc <= ncyc + 1;

    function automatic logic [31:0] rd_data(input logic [29:0] a);
        return a == 30'h100 ? 32'hDEADBEEF : {a, 2'b01} ^ 32'hC3C3_0000;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Flat slave model and issue scoreboard; drives inputs for the coming rising edge.
    always @(negedge clk) begin
        req_t r;
        if (hold)
            chk("stall_stable", 128'({we, sel, addr, mosi_data}), 128'(hold_val));
        ack = 0;
        err = 0;
        miso_data = 32'h5555_AAAA;
        if (!slv_mute && pend.size() != 0 && pend[0].due <= ncyc + 1) begin
            ack = 1;
            miso_data = rd_data(pend[0].addr);
            ack_edges.push_back(ncyc + 1);
            void'(pend.pop_front());
        end
        if (force_ack)
            ack = 1;
        stall = slv_stall_left > 0;
        if (slv_stall_left > 0)
            slv_stall_left--;
        hold = stb & stall;
        hold_val = {we, sel, addr, mosi_data};
        if (stb && !stall) begin
            iss_edges.push_back(ncyc + 1);
            if (!slv_mute)
                pend.push_back('{ncyc + 1 + slv_delay, addr, we});
            if (iss_q.size() == 0)
                chk("unexpected_issue", 128'({we, sel, addr, mosi_data}), 128'(0));
            else begin
                r = iss_q.pop_front();
                chk("issue", 128'({we, sel, addr, mosi_data}), 128'({r.we, r.sel, r.addr, r.data}));
            end
        end
        if (stb)
            stb_hi++;
        if (int'(outstanding) > max_outs)
            max_outs = int'(outstanding);
        if (timeout)
            to_hi++;
    end

    // Response scoreboard on the master side.
    always @(negedge clk) begin
        rsp_t e;
        if (wb_ack || wb_err) begin
            n_rsp++;
            last_rsp_edge = ncyc;
            if (rsp_q.size() == 0)
                chk("unexpected_rsp", 128'({wb_ack, wb_err}), 128'(0));
            else begin
                e = rsp_q.pop_front();
                chk("rsp_kind", 128'({wb_ack, wb_err}), 128'({!e.is_err, e.is_err}));
                if (e.is_rd && !e.is_err)
                    chk("rsp_data", 128'(wb_miso_data), 128'(e.data));
                if (e.is_err)
                    chk("err_with_timeout", 128'(timeout), 128'(1));
            end
        end
    end

    // kind: 0 no response expected, 1 ack, 2 err
    task automatic send(input logic w, input logic [29:0] a, input logic [31:0] d, input int kind);
        int n = 0;
        while (wb_stall && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100)
            chk("accept_timeout", 128'(wb_stall), 128'(0));
        wb_stb = 1;
        wb_we = w;
        wb_addr = a;
        wb_sel = a[3:0] | 4'h1;
        wb_mosi_data = d;
        iss_q.push_back('{w, a[3:0] | 4'h1, a, d});
        if (kind != 0)
            rsp_q.push_back('{kind == 2, !w, rd_data(a)});
        @(negedge clk);
        wb_stb = 0;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((rsp_q.size() != 0 || iss_q.size() != 0) && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk(name, 128'(rsp_q.size() + iss_q.size()), 128'(0));
    endtask

    initial begin
        #10_000_000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "[TB] hang");
    end

    initial begin
        int a0, e0, n;
        repeat (3) @(negedge clk);
        chk("reset_outputs", 128'({cyc, stb, wb_ack, wb_err, wb_stall, outstanding, timeout}), 128'(0));
        reset_n = 1;
        @(negedge clk);

        // single read
        slv_delay = 2;
        stb_hi = 0;
        iss_edges.delete();
        wb_cyc = 1;
        a0 = ncyc + 1;
        send(0, 30'h100, 0, 1);
        @(negedge clk);
        chk("read_outs_1", 128'(outstanding), 128'(1));
        chk("read_issue_edge", 128'(iss_edges[0]), 128'(a0 + 1));
        drain("read_drain");
        chk("read_ack_edge", 128'(last_rsp_edge), 128'(a0 + 3));
        chk("read_outs_0", 128'(outstanding), 128'(0));
        chk("read_stb_cycles", 128'(stb_hi), 128'(1));
        repeat (3) @(negedge clk);
        chk("miso_hold", 128'(wb_miso_data), 128'(32'hDEADBEEF));

        // flat stall backpressure
        slv_delay = 1;
        slv_stall_left = 5;
        @(negedge clk);
        send(1, 30'h200, 32'h1111_0001, 1);
        chk("stall_after_one", 128'(wb_stall), 128'(0));
        send(1, 30'h201, 32'h2222_0002, 1);
        chk("stall_after_two", 128'(wb_stall), 128'(1));
        send(1, 30'h202, 32'h3333_0003, 1);
        drain("stall_drain");
        chk("stall_outs_0", 128'(outstanding), 128'(0));

        // outstanding limit
        slv_delay = 10;
        iss_edges.delete();
        ack_edges.delete();
        max_outs = 0;
        for (int i = 0; i < 6; i++)
            send(0, 30'(32'h300 + i), 0, 1);
        drain("limit_drain");
        chk("limit_max_outs", 128'(max_outs), 128'(4));
        chk("limit_first4_b2b", 128'(iss_edges[3] - iss_edges[0]), 128'(3));
        chk("limit_gap_after_4", 128'(iss_edges[4] - iss_edges[3] > 1), 128'(1));
        chk("limit_5th_after_ack", 128'(iss_edges[4]), 128'(ack_edges[0] + 1));

        // watchdog abort and recovery
        slv_mute = 1;
        iss_edges.delete();
        to_hi = 0;
        send(0, 30'h400, 0, 2);
        drain("wd_drain");
        @(negedge clk);
        chk("wd_err_delay", 128'(last_rsp_edge - iss_edges[0]), 128'(16));
        chk("wd_timeout_pulses", 128'(to_hi), 128'(1));
        chk("wd_cyc_low", 128'(cyc), 128'(0));
        chk("wd_stall_high", 128'(wb_stall), 128'(1));
        chk("wd_outs_0", 128'(outstanding), 128'(0));
        repeat (4) @(negedge clk);
        chk("wd_still_stalled", 128'({wb_stall, stb, cyc}), 128'(3'b100));
        wb_cyc = 0;
        @(negedge clk);
        chk("wd_release", 128'(wb_stall), 128'(0));
        slv_mute = 0;
        slv_delay = 1;
        wb_cyc = 1;
        send(0, 30'h101, 0, 1);
        drain("wd_recover");

        // abandon with two outstanding, ack arriving as the cycle drops and after
        slv_mute = 1;
        send(0, 30'h500, 0, 0);
        send(0, 30'h501, 0, 0);
        n = 0;
        while (outstanding != 2 && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("abandon_outs_2", 128'(outstanding), 128'(2));
        e0 = n_rsp;
        wb_cyc = 0;
        force_ack = 1;
        @(negedge clk);
        chk("abandon_clear", 128'({cyc, stb, outstanding}), 128'(0));
        repeat (3) @(negedge clk);
        force_ack = 0;
        chk("abandon_no_fwd", 128'(n_rsp), 128'(e0));
        slv_mute = 0;

        // asynchronous reset mid-burst
        slv_delay = 3;
        wb_cyc = 1;
        send(1, 30'h600, 32'hA5A5_0600, 1);
        send(1, 30'h601, 32'hA5A5_0601, 1);
        #2 reset_n = 0;
        #1 chk("async_reset", 128'({cyc, stb, wb_ack, wb_err, wb_stall, outstanding, timeout, we, sel, addr, mosi_data, wb_miso_data}), 128'(0));
        wb_cyc = 0;
        @(negedge clk);
        iss_q.delete();
        rsp_q.delete();
        pend.delete();
        chk("reset_hold", 128'({cyc, stb, wb_stall, outstanding}), 128'(0));
        reset_n = 1;
        @(negedge clk);
        slv_delay = 1;
        wb_cyc = 1;
        send(0, 30'h100, 0, 1);
        drain("post_reset");
        wb_cyc = 0;
        @(negedge clk);

`ifdef WB_BRIDGE_STATS_EN
        repeat (2) begin
            slv_mute = 1;
            wb_cyc = 1;
            send(0, 30'h700, 0, 2);
            drain("stats_abort");
            wb_cyc = 0;
            @(negedge clk);
            slv_mute = 0;
            @(negedge clk);
        end
        chk("timeout_count", 128'(timeout_count), 128'(2));
        wb_cyc = 1;
        for (int i = 0; i < 70000; i++)
            send(1, 30'(i), 32'(i), 1);
        drain("stats_drain");
        chk("req_count_sat", 128'(req_count), 128'(16'hFFFF));
        chk("timeout_count_held", 128'(timeout_count), 128'(2));
        wb_cyc = 0;
        @(negedge clk);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
